// File: rtl/red_sched_pkg.sv
// red_sched shared types: field sizes, scheduler states, squaring spread.
package red_sched_pkg;

    localparam int M  = 163;
    localparam int DW = 326;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Squaring in GF(2)[x] interleaves zeros between coefficients.
    function automatic logic [DW-1:0] spread(input logic [M-1:0] a);
        logic [DW-1:0] d;
        d = '0;
        for (int i = 0; i < M; i++) begin
            d[2*i] = a[i];
        end
        return d;
    endfunction

endpackage

// File: rtl/red_sched_red.sv
// red: combinational reduction of a 326-bit product mod x^163+x^7+x^6+x^3+1.
module red
    import red_sched_pkg::*;
(
    input  logic [DW-1:0] d,
    output logic [M-1:0]  r
);

    logic [DW-1:0] t;

    // Folding downward lets each fold's high spill be caught later.
    always_comb begin
        t = d;
        for (int i = DW - 1; i >= M; i--) begin
            if (t[i]) begin
                t[i]         = 1'b0;
                t[i - M]     = ~t[i - M];
                t[i - M + 3] = ~t[i - M + 3];
                t[i - M + 6] = ~t[i - M + 6];
                t[i - M + 7] = ~t[i - M + 7];
            end
        end
        r = t[M-1:0];
    end

endmodule

// File: rtl/red_sched.sv
// red_sched: arbiter/sequencer for the shared reduction unit.
// Define RED_SCHED_RR_EN for round-robin arbitration (default: fixed priority).
module red_sched
    import red_sched_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [DW-1:0]    in0_d,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [M-1:0]     in1_a,
    input  logic [CNT_W-1:0] in1_k,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [M-1:0]     out_r,
    output logic             out_port,
    output logic             busy
);

`ifdef RED_SCHED_RR_EN
    localparam logic FIXED_PRI = 1'b0;
`else
    localparam logic FIXED_PRI = 1'b1;
`endif

    state_t state, state_nx;

    logic [DW-1:0]    d_reg;
    logic [M-1:0]     res;
    logic [CNT_W-1:0] cnt;
    logic             job_port;
    logic             last_grant;
    logic [M-1:0]     r;

    logic grant0, grant1;
    logic idle, k_zero, run_fin, out_fire;

    red u_red (
        .d (d_reg),
        .r (r)
    );

    // last_grant==1 means port 1 went last, so port 0 takes a tie.
    assign grant0 = in0_valid & (~in1_valid | last_grant | FIXED_PRI);
    assign grant1 = in1_valid & ~grant0;

    assign idle      = (state == IDLE);
    assign in0_ready = idle & grant0;
    assign in1_ready = idle & grant1;
    assign k_zero    = (in1_k == '0);
    assign run_fin   = (state == RUN) & (~job_port | (cnt == CNT_W'(1)));
    assign out_fire  = (state == DONE) & out_ready;

    assign out_valid = (state == DONE);
    assign out_r     = res;
    assign out_port  = job_port;
    assign busy      = ~idle;

    always_comb begin
        state_nx = state;
        unique case (1'b1)
            in0_ready:           state_nx = RUN;
            in1_ready & ~k_zero: state_nx = RUN;
            in1_ready &  k_zero: state_nx = DONE;
            run_fin:             state_nx = DONE;
            out_fire:            state_nx = IDLE;
            default:             state_nx = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            d_reg      <= '0;
            res        <= '0;
            cnt        <= '0;
            job_port   <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state <= state_nx;
            if (in0_ready) begin
                d_reg      <= in0_d;
                job_port   <= 1'b0;
                last_grant <= 1'b0;
            end else if (in1_ready) begin
                job_port   <= 1'b1;
                last_grant <= 1'b1;
                if (k_zero) begin
                    res <= in1_a;
                end else begin
                    d_reg <= spread(in1_a);
                    cnt   <= in1_k;
                end
            end else if (state == RUN) begin
                if (run_fin) begin
                    res <= r;
                end else begin
                    d_reg <= spread(r);
                    cnt   <= cnt - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_red_sched.sv
// Directed scoreboard bench for red_sched.
module tb_red_sched;

    logic         clk;
    logic         rst_n;
    logic         in0_valid;
    logic         in0_ready;
    logic [325:0] in0_d;
    logic         in1_valid;
    logic         in1_ready;
    logic [162:0] in1_a;
    logic [7:0]   in1_k;
    logic         out_valid;
    logic         out_ready;
    logic [162:0] out_r;
    logic         out_port;
    logic         busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic         port;
        logic [162:0] r;
        int           lat;
    } exp_t;

    exp_t sb[$];

    red_sched #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in0_d     (in0_d),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .in1_a     (in1_a),
        .in1_k     (in1_k),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_port  (out_port),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [162:0] obs,
                         input logic [162:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic p, input logic [162:0] r, input int lat);
        exp_t e;
        e.port = p;
        e.r    = r;
        e.lat  = lat;
        sb.push_back(e);
    endtask

    // Entered at the negedge after the accepting edge.
    task automatic receive(input int stall);
        int           n;
        exp_t         e;
        logic [162:0] r0;
        logic         p0;
        n = 0;
        while (!out_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("out_valid_rise", 163'(out_valid), 163'(1));
        check("sb_nonempty", 163'(sb.size() != 0), 163'(1));
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("latency", 163'(n), 163'(e.lat));
            check("out_r", out_r, e.r);
            check("out_port", 163'(out_port), 163'(e.port));
        end
        r0 = out_r;
        p0 = out_port;
        if (stall > 0) begin
            in0_valid = 1'b1;
            in0_d     = 326'h1;
        end
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("bp_valid", 163'(out_valid), 163'(1));
            check("bp_r", out_r, r0);
            check("bp_port", 163'(out_port), 163'(p0));
            check("bp_rdy0", 163'(in0_ready), 163'(0));
            check("bp_rdy1", 163'(in1_ready), 163'(0));
            check("bp_busy", 163'(busy), 163'(1));
        end
        out_ready = 1'b1;
        #1;
        check("done_rdy0", 163'(in0_ready), 163'(0));
        if (stall > 0) in0_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_fall", 163'(out_valid), 163'(0));
    endtask

    task automatic send(input logic p, input logic [325:0] d,
                        input logic [162:0] a, input logic [7:0] k,
                        input logic [162:0] er, input int lat,
                        input int stall);
        int n;
        if (p) begin
            in1_valid = 1'b1;
            in1_a     = a;
            in1_k     = k;
        end else begin
            in0_valid = 1'b1;
            in0_d     = d;
        end
        #1;
        n = 0;
        while (!(p ? in1_ready : in0_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready", 163'(p ? in1_ready : in0_ready), 163'(1));
        push(p, er, lat);
        @(negedge clk);
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        receive(stall);
    endtask

    logic [325:0] d;
    logic [162:0] e;

    initial begin
        rst_n     = 1'b0;
        in0_valid = 1'b0;
        in0_d     = '0;
        in1_valid = 1'b0;
        in1_a     = '0;
        in1_k     = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", 163'(out_valid), 163'(0));
        check("rst_r", out_r, 163'(0));
        check("rst_port", 163'(out_port), 163'(0));
        check("rst_busy", 163'(busy), 163'(0));
        check("rst_rdy0", 163'(in0_ready), 163'(0));
        check("rst_rdy1", 163'(in1_ready), 163'(0));
        rst_n = 1'b1;
        @(negedge clk);

        send(1'b0, 326'h1, '0, '0, 163'h1, 1, 0);
        d = '0; d[163] = 1'b1;
        send(1'b0, d, '0, '0, 163'hC9, 1, 0);
        d = '0; d[200] = 1'b1; d[5] = 1'b1;
        e = '0; e[44] = 1'b1; e[43] = 1'b1; e[40] = 1'b1; e[37] = 1'b1;
        e[5] = 1'b1;
        send(1'b0, d, '0, '0, e, 1, 0);
        d = '0; d[325] = 1'b1;
        e = '0; e[162] = 1'b1; e[13] = 1'b1; e[11] = 1'b1; e[6] = 1'b1;
        e[2] = 1'b1;
        send(1'b0, d, '0, '0, e, 1, 0);

        send(1'b1, '0, 163'h2, 8'd1, 163'h4, 1, 0);
        send(1'b1, '0, 163'h2, 8'd3, 163'h100, 3, 0);
        e = '0; e[100] = 1'b1; e[99] = 1'b1; e[96] = 1'b1; e[93] = 1'b1;
        send(1'b1, '0, 163'h2, 8'd8, e, 8, 0);
        send(1'b1, '0, 163'h5, 8'd0, 163'h5, 0, 0);
        send(1'b1, '0, 163'h2, 8'd3, 163'h100, 3, 5);

        in1_valid = 1'b1;
        in1_a     = 163'h2;
        in1_k     = 8'd8;
        #1;
        check("mr_ready", 163'(in1_ready), 163'(1));
        @(negedge clk);
        in1_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mr_valid", 163'(out_valid), 163'(0));
        check("mr_r", out_r, 163'(0));
        check("mr_port", 163'(out_port), 163'(0));
        check("mr_busy", 163'(busy), 163'(0));
        check("mr_rdy0", 163'(in0_ready), 163'(0));
        check("mr_rdy1", 163'(in1_ready), 163'(0));
        rst_n = 1'b1;
        @(negedge clk);
        d = '0; d[163] = 1'b1;
        send(1'b0, d, '0, '0, 163'hC9, 1, 0);

        rst_n     = 1'b0;
        in0_valid = 1'b1;
        in0_d     = 326'h1;
        in1_valid = 1'b1;
        in1_a     = 163'h2;
        in1_k     = 8'd1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("tie_rdy0", 163'(in0_ready), 163'(1));
        check("tie_rdy1", 163'(in1_ready), 163'(0));
        push(1'b0, 163'h1, 1);
        @(negedge clk);
        receive(0);
`ifdef RED_SCHED_RR_EN
        #1;
        check("rr_rdy0", 163'(in0_ready), 163'(0));
        check("rr_rdy1", 163'(in1_ready), 163'(1));
        push(1'b1, 163'h4, 1);
        @(negedge clk);
        receive(0);
`else
        for (int j = 0; j < 3; j++) begin
            #1;
            check("fp_rdy0", 163'(in0_ready), 163'(1));
            check("fp_rdy1", 163'(in1_ready), 163'(0));
            push(1'b0, 163'h1, 1);
            @(negedge clk);
            receive(0);
        end
`endif
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
